// File: rtl/ahb_split_arbiter_if.sv
// Arbiter-facing AHB signal bundle: requests, muxed bus status and split releases in;
// grant, master index, lock status and split mask out.
interface ahb_split_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = $clog2(NUM_MASTERS)
);
   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic                   HREADY;
   logic [1:0]             HRESP;
   logic [NUM_MASTERS-1:0] HSPLIT;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [MW-1:0]          HMASTER;
   logic                   HMASTLOCK;
   logic [NUM_MASTERS-1:0] split_mask;

   // Bus side: masters, muxes and slaves feeding the arbiter.
   modport master (
      output HBUSREQ, HLOCK, HTRANS, HREADY, HRESP, HSPLIT,
      input  HGRANT, HMASTER, HMASTLOCK, split_mask
   );

   // Arbiter side.
   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HREADY, HRESP, HSPLIT,
      output HGRANT, HMASTER, HMASTLOCK, split_mask
   );
endinterface

// File: rtl/ahb_split_arbiter.sv
// Split-aware round-robin AHB arbiter: masters that get a SPLIT response are parked
// until a slave releases them through HSPLIT.
module ahb_split_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MW             = $clog2(NUM_MASTERS)
) (
   input  logic               HCLK,
   input  logic               HRESET,
   ahb_split_arbiter_if.slave bus
);
   localparam logic [1:0] TR_IDLE    = 2'd0;
   localparam logic [1:0] TR_BUSY    = 2'd1;
   localparam logic [1:0] TR_SEQ     = 2'd3;
   localparam logic [1:0] RESP_SPLIT = 2'd3;
   localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

   logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
   logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
   logic [NUM_MASTERS-1:0] split_set, eligible;
   logic [MW-1:0]          hmaster_q, dmaster_q, ptr_q, ptr_d, grant_idx;
   logic                   hmastlock_q, split_hit, lock_hold, burst_hold, found;

   function automatic int rr_idx(input logic [MW-1:0] base, input int step);
      return (int'(base) + step) % NUM_MASTERS;
   endfunction

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (hgrant_q[i]) grant_idx = MW'(i);
      end
   end

   // The default master is never parked, so a SPLIT aimed at it is dropped.
   assign split_hit    = bus.HREADY && (bus.HRESP == RESP_SPLIT) && (dmaster_q != DEF_IDX);
   assign split_set    = split_hit ? (NUM_MASTERS'(1) << dmaster_q) : '0;
   assign split_mask_d = (split_mask_q & ~bus.HSPLIT) | split_set;
   assign eligible     = bus.HBUSREQ & ~split_mask_q & ~split_set;

   assign lock_hold  = hmastlock_q && (bus.HTRANS != TR_IDLE) && !split_hit;
   assign burst_hold = bus.HBUSREQ[grant_idx]
                       && ((bus.HTRANS == TR_SEQ) || (bus.HTRANS == TR_BUSY))
                       && !(split_hit && (dmaster_q == grant_idx));

   always_comb begin
      hgrant_d = DEF_OH;
      ptr_d    = ptr_q;
      found    = 1'b0;
      if (lock_hold || burst_hold) begin
         hgrant_d = hgrant_q;
      end else begin
         for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!found && eligible[rr_idx(ptr_q, k)]) begin
               found    = 1'b1;
               hgrant_d = NUM_MASTERS'(1) << rr_idx(ptr_q, k);
               ptr_d    = MW'(rr_idx(ptr_q, k));
            end
         end
      end
   end

   // Split release is honoured even while the bus is stalled; all else waits for HREADY.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         hgrant_q     <= DEF_OH;
         hmaster_q    <= DEF_IDX;
         dmaster_q    <= DEF_IDX;
         ptr_q        <= DEF_IDX;
         hmastlock_q  <= 1'b0;
         split_mask_q <= '0;
      end else begin
         split_mask_q <= split_mask_d;
         if (bus.HREADY) begin
            dmaster_q   <= hmaster_q;
            hmaster_q   <= grant_idx;
            hmastlock_q <= bus.HLOCK[grant_idx];
            hgrant_q    <= hgrant_d;
            ptr_q       <= ptr_d;
         end
      end
   end

   assign bus.HGRANT     = hgrant_q;
   assign bus.HMASTER    = hmaster_q;
   assign bus.HMASTLOCK  = hmastlock_q;
   assign bus.split_mask = split_mask_q;
endmodule

// File: tb/tb_ahb_split_arbiter.sv
// Directed scoreboard bench for ahb_split_arbiter: each stimulus step queues the
// expected post-edge outputs; a monitor pops and compares after every rising edge.
module tb_ahb_split_arbiter;
   localparam logic [1:0] IDLE = 2'd0, NS = 2'd2, SEQ = 2'd3;
   localparam logic [1:0] OK = 2'd0, SPL = 2'd3;

   typedef struct {
      logic [3:0] g;
      logic [1:0] m;
      logic       l;
      logic [3:0] mask;
      string      nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];

   ahb_split_arbiter_if #(.NUM_MASTERS(4), .MW(2)) bus ();

   ahb_split_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .MW(2)) dut (
      .HCLK  (clk),
      .HRESET(rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic st(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                     input logic rdy, input logic [1:0] rsp, input logic [3:0] spl,
                     input logic [3:0] eg, input logic [1:0] em, input logic el,
                     input logic [3:0] emask, input string nm);
      exp_t e;
      bus.HBUSREQ = req;
      bus.HLOCK   = lk;
      bus.HTRANS  = tr;
      bus.HREADY  = rdy;
      bus.HRESP   = rsp;
      bus.HSPLIT  = spl;
      e.g = eg; e.m = em; e.l = el; e.mask = emask; e.nm = nm;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: compares DUT outputs against the queued expectation after each edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.nm, ".grant"}, {4'b0, bus.HGRANT}, {4'b0, e.g});
         chk({e.nm, ".master"}, {6'b0, bus.HMASTER}, {6'b0, e.m});
         chk({e.nm, ".lock"}, {7'b0, bus.HMASTLOCK}, {7'b0, e.l});
         chk({e.nm, ".mask"}, {4'b0, bus.split_mask}, {4'b0, e.mask});
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      bus.HBUSREQ = '0; bus.HLOCK = '0; bus.HTRANS = IDLE;
      bus.HREADY = 1'b1; bus.HRESP = OK; bus.HSPLIT = '0;
      #1 rst = 1'b1;
      #2;
      chk("rst0.grant", {4'b0, bus.HGRANT}, 8'h01);
      chk("rst0.master", {6'b0, bus.HMASTER}, 8'h00);
      chk("rst0.mask", {4'b0, bus.split_mask}, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Idle bus parks on the default master
      for (int i = 0; i < 3; i++) st(4'b0000, 4'b0, IDLE, 1, OK, 4'b0, 4'b0001, 2'd0, 0, 4'b0000, "idle");

      // Round-robin rotation over masters 1..3
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b0010, 2'd0, 0, 4'b0000, "rr1");
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b0100, 2'd1, 0, 4'b0000, "rr2");
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b1000, 2'd2, 0, 4'b0000, "rr3");
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b0010, 2'd3, 0, 4'b0000, "rr4");
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b0100, 2'd1, 0, 4'b0000, "rr5");
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b1000, 2'd2, 0, 4'b0000, "rr6");
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b0010, 2'd3, 0, 4'b0000, "rr7");

      // Master 2 in data phase gets a two-cycle SPLIT
      st(4'b1110, 4'b0, NS, 0, SPL, 4'b0, 4'b0010, 2'd3, 0, 4'b0000, "split_c1");
      st(4'b1110, 4'b0, NS, 1, SPL, 4'b0, 4'b1000, 2'd1, 0, 4'b0100, "split_c2");
      st(4'b0100, 4'b0, IDLE, 1, OK, 4'b0, 4'b0001, 2'd3, 0, 4'b0100, "parked1");
      st(4'b0100, 4'b0, IDLE, 1, OK, 4'b0, 4'b0001, 2'd0, 0, 4'b0100, "parked2");

      // Release through HSPLIT, then master 2 is granted again
      st(4'b0100, 4'b0, IDLE, 1, OK, 4'b0100, 4'b0001, 2'd0, 0, 4'b0000, "release");
      st(4'b0100, 4'b0, IDLE, 1, OK, 4'b0, 4'b0100, 2'd0, 0, 4'b0000, "regrant");
      st(4'b0100, 4'b0, NS, 1, OK, 4'b0, 4'b0100, 2'd2, 0, 4'b0000, "regrant2");

      // Locked sequence from master 1 with competing requesters
      st(4'b0010, 4'b0010, IDLE, 1, OK, 4'b0, 4'b0010, 2'd2, 0, 4'b0000, "lock_a");
      st(4'b0010, 4'b0010, IDLE, 1, OK, 4'b0, 4'b0010, 2'd1, 1, 4'b0000, "lock_b");
      st(4'b1110, 4'b0010, NS, 1, OK, 4'b0, 4'b0010, 2'd1, 1, 4'b0000, "lock_c");
      st(4'b1110, 4'b0010, SEQ, 1, OK, 4'b0, 4'b0010, 2'd1, 1, 4'b0000, "lock_d");
      st(4'b1110, 4'b0010, SEQ, 1, OK, 4'b0, 4'b0010, 2'd1, 1, 4'b0000, "lock_e");
      st(4'b1110, 4'b0000, IDLE, 1, OK, 4'b0, 4'b0100, 2'd1, 0, 4'b0000, "lock_end");

      // Split master 1 then stall five cycles, releasing it mid-stall
      st(4'b1110, 4'b0, NS, 1, OK, 4'b0, 4'b1000, 2'd2, 0, 4'b0000, "pre_split");
      st(4'b1110, 4'b0, NS, 0, SPL, 4'b0, 4'b1000, 2'd2, 0, 4'b0000, "split1_c1");
      st(4'b1110, 4'b0, NS, 1, SPL, 4'b0, 4'b0100, 2'd3, 0, 4'b0010, "split1_c2");
      st(4'b1000, 4'b0, IDLE, 0, OK, 4'b0, 4'b0100, 2'd3, 0, 4'b0010, "stall1");
      st(4'b0001, 4'b0, IDLE, 0, OK, 4'b0, 4'b0100, 2'd3, 0, 4'b0010, "stall2");
      st(4'b0110, 4'b0, IDLE, 0, OK, 4'b0010, 4'b0100, 2'd3, 0, 4'b0000, "stall3_rel");
      st(4'b1111, 4'b0, IDLE, 0, OK, 4'b0, 4'b0100, 2'd3, 0, 4'b0000, "stall4");
      st(4'b0000, 4'b0, IDLE, 0, OK, 4'b0, 4'b0100, 2'd3, 0, 4'b0000, "stall5");
      st(4'b0010, 4'b0, IDLE, 1, OK, 4'b0, 4'b0010, 2'd2, 0, 4'b0000, "post_stall");

      // Set and release of master 3 on the same edge: set wins
      st(4'b0010, 4'b0, IDLE, 0, SPL, 4'b0, 4'b0010, 2'd2, 0, 4'b0000, "setrel_c1");
      st(4'b0010, 4'b0, IDLE, 1, SPL, 4'b1000, 4'b0010, 2'd1, 0, 4'b1000, "setrel_c2");
      st(4'b0010, 4'b0, IDLE, 1, OK, 4'b0, 4'b0010, 2'd1, 0, 4'b1000, "setrel_idle");

      // SPLIT of the granted master breaks its burst hold
      st(4'b0110, 4'b0, SEQ, 0, SPL, 4'b0, 4'b0010, 2'd1, 0, 4'b1000, "gsplit_c1");
      st(4'b0110, 4'b0, SEQ, 1, SPL, 4'b0, 4'b0100, 2'd1, 0, 4'b1010, "gsplit_c2");

      // Asynchronous reset in the middle of a burst
      bus.HBUSREQ = 4'b0100; bus.HTRANS = SEQ; bus.HRESP = OK; bus.HREADY = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("arst.grant", {4'b0, bus.HGRANT}, 8'h01);
      chk("arst.master", {6'b0, bus.HMASTER}, 8'h00);
      chk("arst.lock", {7'b0, bus.HMASTLOCK}, 8'h00);
      chk("arst.mask", {4'b0, bus.split_mask}, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Unlocked burst hold on SEQ, released on NONSEQ
      st(4'b0110, 4'b0, NS, 1, OK, 4'b0, 4'b0010, 2'd0, 0, 4'b0000, "burst_a");
      st(4'b0110, 4'b0, SEQ, 1, OK, 4'b0, 4'b0010, 2'd1, 0, 4'b0000, "burst_b");
      st(4'b0110, 4'b0, SEQ, 1, OK, 4'b0, 4'b0010, 2'd1, 0, 4'b0000, "burst_c");
      st(4'b0110, 4'b0, NS, 1, OK, 4'b0, 4'b0100, 2'd1, 0, 4'b0000, "burst_d");
      st(4'b0000, 4'b0, IDLE, 1, OK, 4'b0, 4'b0001, 2'd2, 0, 4'b0000, "burst_e");

      @(posedge clk);
      #2;
      chk("queue_drained", 8'(q.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
